// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer for a 1-cycle-latency instruction ROM
//
// Purpose:
//   Owns the program counter and presents it every cycle as the ROM read address.
//   Pairs each returning word with the PC it was fetched from and hands it to decode
//   over a valid/ready handshake. A single skid entry absorbs the one word that is
//   already in flight when decode stalls. A redirect squashes everything in flight
//   and restarts fetch at the target.
//
// Ports:
//   clk                - system clock, all state on the rising edge
//   rst                - asynchronous, active-high reset
//   fetch_enable_in    - 1 allows new fetches; 0 stops issuing, in-flight words still drain
//   redirect_valid_in  - branch/jump taken this cycle (highest priority)
//   redirect_pc_in     - redirect target, bits [1:0] forced to zero
//   imem_addr_out      - ROM read address (current PC)
//   imem_data_in       - ROM word for the address presented in the previous cycle
//   instr_valid_out    - instruction presented to decode
//   instr_out          - instruction word, NOP (0x00000013) when not valid
//   instr_pc_out       - PC of instr_out, 0 when not valid
//   instr_ready_in     - decode accepts; a transfer is valid & ready
//   fetch_count_out    - number of accepted instructions, wraps mod 2^32

module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  input  logic        instr_ready_in,
  output logic [31:0] fetch_count_out
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc_q;
  logic        r_inflight_q;
  logic [31:0] r_inflight_pc_q;
  logic        r_skid_full_q;
  logic [31:0] r_skid_instr_q;
  logic [31:0] r_skid_pc_q;
  logic [31:0] r_fetch_count_q;

  logic        w_issue;
  logic        w_valid;
  logic        w_xfer;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic [31:0] w_redirect_target;

  // The low two target bits are dropped by word alignment.
  logic        w_unused_redirect_lsbs;
  assign w_unused_redirect_lsbs = ^redirect_pc_in[1:0];

  assign w_redirect_target = {redirect_pc_in[31:2], 2'b00};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; redirects never change state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (fetch_enable_in)  w_state_next = ST_RUN;
      ST_RUN:  if (!fetch_enable_in) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: issue decision and the decode-side output mux
  always_comb begin
    // A new fetch is only safe when whatever currently holds a word (the
    // in-flight slot or the skid entry) is being drained this same cycle;
    // otherwise the returning word would have nowhere to go.
    w_issue = (r_state == ST_RUN) && fetch_enable_in && !redirect_valid_in &&
              (!r_inflight_q || instr_ready_in) &&
              (!r_skid_full_q || instr_ready_in);

    w_valid    = 1'b0;
    w_instr    = NOP_INSTR;
    w_instr_pc = 32'h0000_0000;
    // Redirect squashes the presented word so nothing transfers this cycle.
    if (!redirect_valid_in) begin
      if (r_skid_full_q) begin
        w_valid    = 1'b1;
        w_instr    = r_skid_instr_q;
        w_instr_pc = r_skid_pc_q;
      end else if (r_inflight_q) begin
        w_valid    = 1'b1;
        w_instr    = imem_data_in;
        w_instr_pc = r_inflight_pc_q;
      end
    end

    w_xfer = w_valid && instr_ready_in;
  end

  // PC, in-flight tracking and skid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_q          <= {RESET_PC[31:2], 2'b00};
      r_inflight_q    <= 1'b0;
      r_inflight_pc_q <= 32'h0000_0000;
      r_skid_full_q   <= 1'b0;
      r_skid_instr_q  <= NOP_INSTR;
      r_skid_pc_q     <= 32'h0000_0000;
    end else if (redirect_valid_in) begin
      r_pc_q        <= w_redirect_target;
      r_inflight_q  <= 1'b0;
      r_skid_full_q <= 1'b0;
    end else begin
      r_inflight_q <= w_issue;
      if (w_issue) begin
        r_inflight_pc_q <= r_pc_q;
        r_pc_q          <= r_pc_q + PC_STEP;
      end
      // The ROM has no read enable, so a stalled in-flight word must be
      // captured now; next cycle the data bus carries a different word.
      if (r_inflight_q && !r_skid_full_q && !instr_ready_in) begin
        r_skid_full_q  <= 1'b1;
        r_skid_instr_q <= imem_data_in;
        r_skid_pc_q    <= r_inflight_pc_q;
      end else if (r_skid_full_q && instr_ready_in) begin
        r_skid_full_q <= 1'b0;
      end
    end
  end

  // Accepted-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count_q <= 32'h0000_0000;
    end else if (w_xfer) begin
      r_fetch_count_q <= r_fetch_count_q + 32'd1;
    end
  end

  assign imem_addr_out   = r_pc_q;
  assign instr_valid_out = w_valid;
  assign instr_out       = w_instr;
  assign instr_pc_out    = w_instr_pc;
  assign fetch_count_out = r_fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller with directed and random traffic
module tb_fetch_controller;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_enable_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in = 32'h0;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_ready_in;
  logic [31:0] fetch_count_out;

  logic [31:0] rom [16];
  logic [31:0] prog [5];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] m_next_pc;
  logic [31:0] m_count;
  int          m_total = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  fetch_controller #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_enable_in   (fetch_enable_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_pc_in    (redirect_pc_in),
    .imem_addr_out     (imem_addr_out),
    .imem_data_in      (imem_data_in),
    .instr_valid_out   (instr_valid_out),
    .instr_out         (instr_out),
    .instr_pc_out      (instr_pc_out),
    .instr_ready_in    (instr_ready_in),
    .fetch_count_out   (fetch_count_out)
  );

  initial forever #5 clk = ~clk;

  // 16-word synchronous ROM, word index from address bits [5:2]
  always @(posedge clk) imem_data_in <= rom[imem_addr_out[5:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: delivered stream is consecutive words from the last
  // start point (reset or redirect target), each paired with its ROM word.
  task automatic refill();
    while (sb_q.size() < 8) begin
      sb_q.push_back('{pc: m_next_pc, word: rom[m_next_pc[5:2]]});
      m_next_pc = m_next_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid_in = 1'b0;
    sb_q.delete();
    m_next_pc = RESET_PC;
    refill();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid_in = 1'b1;
    redirect_pc_in = t;
    sb_q.delete();
    m_next_pc = {t[31:2], 2'b00};
    refill();
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0: return r & 32'h0000_00FF;
      1: return 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      default: return r;
    endcase
  endfunction

  task automatic expect_cycle(input string nm, input bit v, input logic [31:0] pc,
                              input logic [31:0] w, input logic [31:0] addr);
    @(negedge clk);
    chk({nm, ".valid"}, {31'd0, instr_valid_out}, {31'd0, v});
    chk({nm, ".addr"}, imem_addr_out, addr);
    if (v) begin
      chk({nm, ".pc"}, instr_pc_out, pc);
      chk({nm, ".instr"}, instr_out, w);
    end else begin
      chk({nm, ".nop"}, instr_out, NOP);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_count = 32'd0;
      chk("rst.valid", {31'd0, instr_valid_out}, 32'd0);
    end else begin
      chk("fetch_count", fetch_count_out, m_count);
      n_checks++;
      assert (!(dut.r_skid_full_q && dut.r_inflight_q)) n_pass++;
      else $display("FAIL skid_invariant: skid_full=%b inflight=%b required inflight=0",
                    dut.r_skid_full_q, dut.r_inflight_q);
      if (redirect_valid_in) chk("redirect.squash", {31'd0, instr_valid_out}, 32'd0);
      if (!instr_valid_out) begin
        chk("idle.instr", instr_out, NOP);
        chk("idle.pc", instr_pc_out, 32'd0);
      end else if (instr_ready_in) begin
        chk("sb.nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("xfer.pc", instr_pc_out, e.pc);
          chk("xfer.instr", instr_out, e.word);
          m_count = m_count + 32'd1;
          m_total++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_enable_in = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in = 32'h0;
    instr_ready_in = 1'b1;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0030_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0030_2023;
    prog[4] = NOP;
    for (int i = 0; i < 16; i++) rom[i] = (i < 4) ? prog[i] : NOP;

    // Straight-line fetch with ready held high
    fetch_enable_in = 1'b1;
    reset_dut();
    expect_cycle("t1.c0", 1'b0, 32'd0, NOP, RESET_PC); tick();
    expect_cycle("t1.c1", 1'b0, 32'd0, NOP, RESET_PC); tick();
    for (int k = 0; k < 5; k++) begin
      expect_cycle("t1.seq", 1'b1, 4 * k, prog[k], 4 * k + 4);
      if (k == 4) chk("t1.count", fetch_count_out, 32'd4);
      tick();
    end

    // Decode stall while PC 4 is presented
    reset_dut(); tick(); tick();
    expect_cycle("t2.c2", 1'b1, 32'd0, prog[0], 32'd4); tick();
    instr_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("t2.hold", 1'b1, 32'd4, prog[1], 32'd8); tick();
    end
    instr_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("t2.drain", 1'b1, 4 + 4 * k, prog[1 + k], 8 + 4 * k); tick();
    end

    // Redirect with skid full and ready low
    reset_dut(); tick(); tick();
    expect_cycle("t3.c2", 1'b1, 32'd0, prog[0], 32'd4); tick();
    instr_ready_in = 1'b0;
    expect_cycle("t3.c3", 1'b1, 32'd4, prog[1], 32'd8); tick();
    do_redirect(32'h0000_0009);
    expect_cycle("t3.redir", 1'b0, 32'd0, NOP, 32'd8); tick();
    redirect_valid_in = 1'b0;
    instr_ready_in = 1'b1;
    expect_cycle("t3.c5", 1'b0, 32'd0, NOP, 32'd8);
    chk("t3.count", fetch_count_out, 32'd1);
    tick();
    expect_cycle("t3.target", 1'b1, 32'd8, prog[2], 32'd12); tick();

    // Fetch enable dropped after PC 12 is issued, then resumed
    reset_dut(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      expect_cycle("t4.run", 1'b1, 4 * k, prog[k], 4 * k + 4); tick();
    end
    fetch_enable_in = 1'b0;
    expect_cycle("t4.last", 1'b1, 32'd12, prog[3], 32'd16); tick();
    for (int k = 0; k < 2; k++) begin
      expect_cycle("t4.off", 1'b0, 32'd0, NOP, 32'd16); tick();
    end
    fetch_enable_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_cycle("t4.wake", 1'b0, 32'd0, NOP, 32'd16); tick();
    end
    expect_cycle("t4.resume", 1'b1, 32'd16, NOP, 32'd20); tick();

    // Asynchronous reset mid-cycle with skid full
    reset_dut(); tick(); tick();
    expect_cycle("t5.c2", 1'b1, 32'd0, prog[0], 32'd4); tick();
    instr_ready_in = 1'b0;
    expect_cycle("t5.c3", 1'b1, 32'd4, prog[1], 32'd8); tick();
    expect_cycle("t5.skid", 1'b1, 32'd4, prog[1], 32'd8);
    #2;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("t5.valid", {31'd0, instr_valid_out}, 32'd0);
    chk("t5.instr", instr_out, NOP);
    chk("t5.pc", instr_pc_out, 32'd0);
    chk("t5.addr", imem_addr_out, RESET_PC);
    chk("t5.count", fetch_count_out, 32'd0);
    m_next_pc = RESET_PC;
    refill();
    tick();
    tick();
    rst = 1'b0;
    instr_ready_in = 1'b1;

    // Random traffic against the scoreboard
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        reset_dut();
      end
      fetch_enable_in = ($urandom_range(0, 9) != 0);
      instr_ready_in = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) do_redirect(pick_target());
      else redirect_valid_in = 1'b0;
      tick();
    end
    redirect_valid_in = 1'b0;
    @(negedge clk);
    chk("random.progress", {31'd0, m_total > 600}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
